// File: rtl/grad_batch_accumulator_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : grad_batch_accumulator_pkg                                      |
// | Purpose  : Shared fixed-point constants and types for the gradient          |
// |            batch accumulator (Q8.8 words, FSM state encoding).              |
// | Contents : FXP_DATA_W, FXP_FRAC_W, fxp_t, gba_state_t                       |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package grad_batch_accumulator_pkg;

   localparam int FXP_DATA_W = 16;
   localparam int FXP_FRAC_W = 8;

   typedef logic signed [FXP_DATA_W-1:0] fxp_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DRAIN = 2'd2
   } gba_state_t;

endpackage
`default_nettype wire

// File: rtl/grad_acc_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : grad_acc_bank                                                    |
// | Purpose  : DEPTH x ACC_W accumulator register array with a write-or-add     |
// |            port and an asynchronous read port.                              |
// | Ports    : clk                 clock                                        |
// |            wr_en               perform a write/add this cycle              |
// |            clear_sel           1: overwrite with wr_data, 0: add wr_data   |
// |            wr_addr / wr_data   target entry and (sign-extended) operand    |
// |            rd_addr / rd_data   combinational read of one entry             |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module grad_acc_bank #(
   parameter int DEPTH  = 4,
   parameter int ACC_W  = 18,
   parameter int ADDR_W = 2
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic              clear_sel,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [ACC_W-1:0]  wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [ACC_W-1:0]  rd_data
);

   // Contents need no reset: the first sample of each batch overwrites them.
   logic [ACC_W-1:0] acc [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         // Two's-complement add is sign-agnostic, so no signed typing needed.
         acc[wr_addr] <= clear_sel ? wr_data : acc[wr_addr] + wr_data;
      end
   end

   assign rd_data = acc[rd_addr];

endmodule
`default_nettype wire

// File: rtl/grad_batch_accumulator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : grad_batch_accumulator                                           |
// | Purpose  : Sums 2^LOG2_BATCH per-sample Q8.8 gradient vectors element-wise  |
// |            and drains the batch average one element per cycle.             |
// | Ports    : clk, rst (async, active-high)                                    |
// |            start_in                      begin a batch (IDLE only)          |
// |            grad_in / grad_valid_in       per-sample element stream          |
// |            grad_ready_out                high while accumulating            |
// |            grad_out / grad_valid_out     averaged element stream            |
// |            grad_idx_out / grad_last_out  element index / final element      |
// |            busy_out                      high in ACCUM or DRAIN             |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module grad_batch_accumulator
   import grad_batch_accumulator_pkg::*;
#(
   parameter int DEPTH      = 4,
   parameter int LOG2_BATCH = 2,
   parameter int DATA_W     = FXP_DATA_W,
   parameter int IDX_W      = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_in,
   input  logic [DATA_W-1:0] grad_in,
   input  logic              grad_valid_in,
   output logic              grad_ready_out,
   output logic [DATA_W-1:0] grad_out,
   output logic              grad_valid_out,
   output logic [IDX_W-1:0]  grad_idx_out,
   output logic              grad_last_out,
   output logic              busy_out
);

   // One guard bit per doubling of the batch makes overflow impossible.
   localparam int ACC_W = DATA_W + LOG2_BATCH;

   localparam logic [1:0] ST_IDLE  = IDLE;
   localparam logic [1:0] ST_ACCUM = ACCUM;
   localparam logic [1:0] ST_DRAIN = DRAIN;

   localparam logic [IDX_W-1:0]    LAST_ELEM   = IDX_W'(DEPTH - 1);
   localparam logic [LOG2_BATCH:0] LAST_SAMPLE = (LOG2_BATCH + 1)'((2 ** LOG2_BATCH) - 1);
   localparam logic [IDX_W:0]      DRAIN_END   = (IDX_W + 1)'(DEPTH);

   logic [1:0]            state;
   logic [IDX_W-1:0]      elem_cnt;
   logic [LOG2_BATCH:0]   sample_cnt;
   logic [IDX_W:0]        drain_cnt;

   logic                  xfer;
   logic                  drain_emit;
   logic [ACC_W-1:0]      grad_ext;
   logic [IDX_W-1:0]      rd_addr;
   logic [ACC_W-1:0]      acc_rd;
   logic [DATA_W-1:0]     avg;

   assign grad_ready_out = (state == ST_ACCUM);
   assign busy_out       = (state != ST_IDLE);
   assign xfer           = grad_valid_in && grad_ready_out;
   assign grad_ext       = ACC_W'($signed(grad_in));

   // DRAIN lasts DEPTH+1 cycles: DEPTH emit cycles, then one cycle in which
   // the last registered element is on the outputs before returning to IDLE.
   assign drain_emit     = (state == ST_DRAIN) && (drain_cnt < DRAIN_END);
   assign rd_addr        = drain_emit ? drain_cnt[IDX_W-1:0] : '0;

   // Arithmetic shift floors; the quotient always fits back in DATA_W.
   assign avg            = DATA_W'($signed(acc_rd) >>> LOG2_BATCH);

   grad_acc_bank #(
      .DEPTH  (DEPTH),
      .ACC_W  (ACC_W),
      .ADDR_W (IDX_W)
   ) u_bank (
      .clk       (clk),
      .wr_en     (xfer),
      .clear_sel (sample_cnt == '0),
      .wr_addr   (elem_cnt),
      .wr_data   (grad_ext),
      .rd_addr   (rd_addr),
      .rd_data   (acc_rd)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         elem_cnt   <= '0;
         sample_cnt <= '0;
         drain_cnt  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start_in) begin
                  state      <= ST_ACCUM;
                  elem_cnt   <= '0;
                  sample_cnt <= '0;
               end
            end
            ST_ACCUM: begin
               if (xfer) begin
                  if (elem_cnt == LAST_ELEM) begin
                     elem_cnt <= '0;
                     if (sample_cnt == LAST_SAMPLE) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= '0;
                     end else begin
                        sample_cnt <= sample_cnt + 1'b1;
                     end
                  end else begin
                     elem_cnt <= elem_cnt + 1'b1;
                  end
               end
            end
            ST_DRAIN: begin
               if (drain_cnt == DRAIN_END) begin
                  state <= ST_IDLE;
               end else begin
                  drain_cnt <= drain_cnt + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Registered output stream; zero whenever no element is being presented.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grad_out       <= '0;
         grad_valid_out <= 1'b0;
         grad_idx_out   <= '0;
         grad_last_out  <= 1'b0;
      end else if (drain_emit) begin
         grad_out       <= avg;
         grad_valid_out <= 1'b1;
         grad_idx_out   <= drain_cnt[IDX_W-1:0];
         grad_last_out  <= (drain_cnt[IDX_W-1:0] == LAST_ELEM);
      end else begin
         grad_out       <= '0;
         grad_valid_out <= 1'b0;
         grad_idx_out   <= '0;
         grad_last_out  <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_grad_batch_accumulator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_grad_batch_accumulator                                        |
// | Purpose  : Scoreboard bench for grad_batch_accumulator (DEPTH=4, batch=4).  |
// |            Expected averages come from integer floor division of the sum.  |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_grad_batch_accumulator;

   localparam int DEPTH      = 4;
   localparam int LOG2_BATCH = 2;
   localparam int NS         = 4;
   localparam int DW         = 16;
   localparam int IW         = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start_in = 1'b0;
   logic [DW-1:0] grad_in = '0;
   logic          grad_valid_in = 1'b0;
   logic          grad_ready_out;
   logic [DW-1:0] grad_out;
   logic          grad_valid_out;
   logic [IW-1:0] grad_idx_out;
   logic          grad_last_out;
   logic          busy_out;

   grad_batch_accumulator #(
      .DEPTH      (DEPTH),
      .LOG2_BATCH (LOG2_BATCH),
      .DATA_W     (DW),
      .IDX_W      (IW)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start_in       (start_in),
      .grad_in        (grad_in),
      .grad_valid_in  (grad_valid_in),
      .grad_ready_out (grad_ready_out),
      .grad_out       (grad_out),
      .grad_valid_out (grad_valid_out),
      .grad_idx_out   (grad_idx_out),
      .grad_last_out  (grad_last_out),
      .busy_out       (busy_out)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [DW-1:0] data;
      int            idx;
      bit            last;
      int            cyc_due;
   } exp_t;

   exp_t          sbq[$];
   exp_t          mon_e;
   int            n_checks = 0;
   int            n_pass   = 0;
   logic [DW-1:0] batch [NS][DEPTH];

   task automatic check(input bit ok, input string name, input longint act, input longint req);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
   endtask

   // Reference: mean of the batch column, rounded toward minus infinity.
   function automatic logic [DW-1:0] ref_avg(input int e);
      int sum;
      int q;
      sum = 0;
      for (int s = 0; s < NS; s++) sum += int'($signed(batch[s][e]));
      q = sum / NS;
      if ((sum % NS) != 0 && sum < 0) q = q - 1;
      return q[DW-1:0];
   endfunction

   // Monitor: every valid output is popped against the scoreboard, including
   // the exact cycle it is due; idle cycles must present zeros.
   always @(negedge clk) begin
      if (grad_valid_out) begin
         if (sbq.size() == 0) begin
            check(1'b0, "unexpected_valid", longint'(grad_idx_out), 0);
         end else begin
            mon_e = sbq.pop_front();
            check(grad_out == mon_e.data, "grad_out", grad_out, mon_e.data);
            check(int'(grad_idx_out) == mon_e.idx, "grad_idx_out", grad_idx_out, mon_e.idx);
            check(grad_last_out == mon_e.last, "grad_last_out", grad_last_out, mon_e.last);
            check(cyc == mon_e.cyc_due, "output_cycle", cyc, mon_e.cyc_due);
         end
      end else begin
         check(grad_out == '0 && !grad_last_out && grad_idx_out == '0, "idle_zero",
               {grad_last_out, grad_idx_out, grad_out}, 0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Starts a batch (with junk on grad_in during the start cycle, which must
   // be ignored), feeds all samples and pushes the expected drain stream.
   task automatic load_batch(input int max_bubble, input int n_xfer, output int t_last);
      @(negedge clk);
      check(!grad_ready_out && !busy_out, "idle_ready_busy", {grad_ready_out, busy_out}, 0);
      start_in      = 1'b1;
      grad_valid_in = 1'b1;
      grad_in       = DW'($urandom);
      tick();
      start_in      = 1'b0;
      t_last        = 0;
      for (int k = 0; k < n_xfer; k++) begin
         grad_valid_in = 1'b0;
         repeat ($urandom_range(0, max_bubble)) tick();
         grad_valid_in = 1'b1;
         grad_in       = batch[k / DEPTH][k % DEPTH];
         t_last        = cyc;
         @(negedge clk);
         check(grad_ready_out && busy_out, "accum_ready_busy", {grad_ready_out, busy_out}, 3);
         tick();
      end
      // Valid stays high with junk data while the block must not accept it.
      grad_in = DW'($urandom);
      if (n_xfer == NS * DEPTH) begin
         for (int e = 0; e < DEPTH; e++)
            sbq.push_back('{data: ref_avg(e), idx: e, last: (e == DEPTH - 1), cyc_due: t_last + 2 + e});
      end
   endtask

   task automatic run_batch(input int max_bubble, input bit drain_start);
      int t;
      load_batch(max_bubble, NS * DEPTH, t);
      if (drain_start) begin
         tick();
         start_in = 1'b1;
         tick();
         start_in = 1'b0;
      end
      while (cyc < t + 1 + DEPTH) tick();
      @(negedge clk);
      check(busy_out && !grad_ready_out, "busy_last_elem", {busy_out, grad_ready_out}, 2);
      grad_valid_in = 1'b0;
      @(negedge clk);
      check(!busy_out && !grad_ready_out, "busy_after_last", {busy_out, grad_ready_out}, 0);
      check(sbq.size() == 0, "drained_all", sbq.size(), 0);
      sbq.delete();
      #1;
   endtask

   task automatic fill_random();
      for (int s = 0; s < NS; s++)
         for (int e = 0; e < DEPTH; e++) batch[s][e] = DW'($urandom);
   endtask

   task automatic fill_const(input logic [DW-1:0] v);
      for (int s = 0; s < NS; s++)
         for (int e = 0; e < DEPTH; e++) batch[s][e] = v;
   endtask

   task automatic pulse_reset();
      @(posedge clk);
      #2;
      rst = 1'b1;
      sbq.delete();
      grad_valid_in = 1'b0;
      @(negedge clk);
      check(grad_out == '0 && !grad_valid_out && grad_idx_out == '0 && !grad_last_out
            && !busy_out && !grad_ready_out, "reset_outputs",
            {grad_out, grad_valid_out, grad_idx_out, grad_last_out, busy_out, grad_ready_out}, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      int t;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check(grad_out == '0 && !grad_valid_out && grad_idx_out == '0 && !grad_last_out
            && !busy_out && !grad_ready_out, "power_on_reset",
            {grad_out, grad_valid_out, grad_idx_out, grad_last_out, busy_out, grad_ready_out}, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Directed mixed-sign vectors.
      batch[0] = '{16'h0100, 16'h0200, 16'hFF00, 16'h0080};
      batch[1] = '{16'h0300, 16'h0200, 16'hFE00, 16'h0081};
      batch[2] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
      batch[3] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
      run_batch(0, 1'b0);

      // Floor rounding: +1/4 -> 0, -1/4 -> -1, +3/4 -> 0, -3/4 -> -1.
      fill_const(16'h0000);
      batch[0] = '{16'h0001, 16'hFFFF, 16'h0003, 16'hFFFD};
      run_batch(0, 1'b0);

      // Range extremes must not wrap.
      for (int s = 0; s < NS; s++) batch[s] = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000};
      run_batch(0, 1'b0);

      // Bubbles plus a start pulse during DRAIN.
      fill_random();
      run_batch(3, 1'b1);

      // Next batch straight after: constant data proves the implicit clear.
      fill_const(16'h0010);
      run_batch(0, 1'b0);

      // Reset after 5 transfers, then a fresh batch.
      fill_const(16'h4000);
      load_batch(0, 5, t);
      pulse_reset();
      fill_random();
      run_batch(1, 1'b0);

      // Reset in the middle of the drain stream, then a fresh batch.
      fill_const(16'h7000);
      load_batch(0, NS * DEPTH, t);
      while (cyc < t + 3) tick();
      pulse_reset();
      fill_const(16'hFFF0);
      run_batch(0, 1'b0);

      for (int b = 0; b < 6; b++) begin
         fill_random();
         run_batch(2, b[0]);
      end

      check(sbq.size() == 0, "final_queue_empty", sbq.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Hard stop if the stimulus ever stalls.
   initial begin
      #200000;
      $display("FAIL timeout: got cycle %0d required completion", cyc);
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire

// File: doc/grad_batch_accumulator.md
Name: grad_batch_accumulator

Overview:
- Upstream neighbour of the gradient-descent update stage.
- Collects per-sample gradient vectors (Q8.8, 16-bit signed) over a mini-batch, sums them element-wise in widened accumulators, then drains the batch-averaged gradient one element per cycle.
- Output stream (grad_out, grad_valid_out, grad_idx_out) drives the update stage's grad input, valid and parameter addressing directly.
- Lets the update stage run once per batch instead of once per sample.

Parameters:
- DEPTH, 4: elements per gradient vector (weights/biases per column); ≥2.
- LOG2_BATCH, 2: batch size = 2^LOG2_BATCH samples; 0..8.
- DATA_W, 16: fixed-point word width (Q8.8).
- IDX_W, $clog2(DEPTH): element index width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_in  in  1  one-cycle pulse; begins a new batch (honoured only in IDLE).
- grad_in  in  DATA_W  signed Q8.8 per-sample gradient element.
- grad_valid_in  in  1  grad_in valid this cycle.
- grad_ready_out  out  1  block accepts grad_in this cycle.
- grad_out  out  DATA_W  signed Q8.8 batch-averaged gradient.
- grad_valid_out  out  1  grad_out/grad_idx_out valid.
- grad_idx_out  out  IDX_W  element index of grad_out.
- grad_last_out  out  1  high with the final drained element (idx DEPTH-1).
- busy_out  out  1  high in ACCUM or DRAIN.

Behaviour:
- Reset (async): state IDLE, all counters 0; grad_out=0, grad_valid_out=0, grad_idx_out=0, grad_last_out=0, busy_out=0, grad_ready_out=0. Accumulator contents don't care.
- States: IDLE, ACCUM, DRAIN.
- IDLE:
  - grad_ready_out=0.
  - start_in=1 → ACCUM next cycle; elem_cnt=0, sample_cnt=0.
  - grad_valid_in is ignored in IDLE, including the start cycle.
- ACCUM:
  - grad_ready_out=1. Transfer when grad_valid_in && grad_ready_out.
  - Each transfer targets acc[elem_cnt].
  - If sample_cnt==0: acc ← sign-extended grad_in (implicit clear, no clear cycles). Otherwise acc ← acc + sign-extended grad_in.
  - elem_cnt increments per transfer; at DEPTH-1 it wraps to 0 and sample_cnt increments.
  - Transfer with elem_cnt==DEPTH-1 and sample_cnt==2^LOG2_BATCH-1 → DRAIN next cycle.
  - Bubbles (valid low) are allowed; the state holds.
- Accumulator width: DATA_W+LOG2_BATCH bits, signed. Overflow is impossible by construction.
- Averaging: grad_out = acc >>> LOG2_BATCH (arithmetic shift, floor rounding), truncated to DATA_W. The result is always in range, so no saturation.
- DRAIN:
  - grad_ready_out=0.
  - Emits one element per cycle, idx 0..DEPTH-1, registered outputs.
  - If the last transfer is in cycle t: grad_valid_out is high in cycles t+2 … t+1+DEPTH, grad_idx_out=k in cycle t+2+k.
  - grad_last_out is high with idx DEPTH-1.
  - Returns to IDLE in the cycle after the last element. No backpressure: downstream accepts every cycle.
- Outside valid cycles: grad_out=0, grad_valid_out=0, grad_last_out=0 (matches the update stage's zero-when-idle convention).
- busy_out=1 in ACCUM and DRAIN.
- start_in outside IDLE is ignored.
- A start_in in the same cycle the FSM re-enters IDLE is honoured the following cycle only if still asserted.
- rst mid-ACCUM or mid-DRAIN: immediate return to IDLE, outputs to reset values. The partial batch is discarded and the next start_in begins clean.

Decomposition:
- Shared fxp package:
  - DATA_W=16, FRAC_W=8 constants.
  - fxp_t typedef (signed [15:0]).
  - State enum gba_state_t {IDLE, ACCUM, DRAIN}.
- One natural sub-module, grad_acc_bank:
  - DEPTH×(DATA_W+LOG2_BATCH) register array.
  - Write-or-add port (clear_sel, addr, data) and a read port.
- FSM, counters and averaging shift stay in the top.

Test Plan:
- DEPTH=4, LOG2_BATCH=1: sample0 {0x0100,0x0200,0xFF00,0x0080}, sample1 {0x0300,0x0200,0xFE00,0x0081} → outputs {0x0200,0x0200,0xFE80,0x0080} at idx 0..3, grad_last_out with idx 3.
- Floor rounding: LOG2_BATCH=1, element samples 0x0001 and 0x0000 → 0x0000; samples 0xFFFF and 0x0000 → 0xFFFF.
- Range extremes: LOG2_BATCH=2, four samples of 0x7FFF → 0x7FFF; four of 0x8000 → 0x8000; no wrap.
- Bubbles and latency: insert 3 idle cycles between transfers → same result; first grad_valid_out exactly 2 cycles after the final transfer; DEPTH consecutive valid cycles; busy_out drops the cycle after last.
- Back-to-back batches: a second batch directly after the first, with all gradients 0x0010 → output 0x0010 everywhere, proving the implicit clear. start_in during DRAIN has no effect.
- Reset mid-ACCUM after 5 transfers: all outputs 0, ready 0. A fresh batch then averages correctly with no stale contributions.
